// File: rtl/mac_div_pkg.sv
// Shared types and constants for the sequential 16/8 restoring divider.
package mac_div_pkg;
    localparam int DW = 16;
    localparam int VW = 8;
    localparam logic [DW-1:0] QUO_DZ = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int VW = mac_div_pkg::VW
) (
    input  logic [VW:0]   rem_in,
    input  logic          dvd_bit,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   rem_out,
    output logic          q_bit
);
    import mac_div_pkg::*;

    // One extra bit on top so the shifted value never wraps before the compare.
    logic [VW+1:0] shifted;
    logic [VW+1:0] dvs_ext;

    always_comb begin
        shifted = {rem_in, dvd_bit};
        dvs_ext = {2'b00, divisor};
        q_bit   = (shifted >= dvs_ext);
        rem_out = (VW+1)'(q_bit ? (shifted - dvs_ext) : shifted);
    end
endmodule

// File: rtl/mac_divider.sv
// Sequential unsigned divider resolving one quotient bit per clock, MSB first.
module mac_divider #(
    parameter int DW = mac_div_pkg::DW,
    parameter int VW = mac_div_pkg::VW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] Dividend,
    input  logic [VW-1:0] Divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] Quo,
    output logic [VW-1:0] Rem,
    output logic          div_zero
);
    import mac_div_pkg::*;

    localparam int CW = $clog2(DW);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dvd_sh;
    logic [VW-1:0] dvs;
    logic [VW:0]   rem_work, rem_nxt;
    logic          q_bit;
    logic          accept, last_step;

    assign accept    = start && (state != CALC);
    assign last_step = (state == CALC) && (cnt == CW'(DW-1));
    assign busy      = (state == CALC);
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_nxt = (Divisor == '0) ? DONE : CALC;
                else       state_nxt = IDLE;
            end
            CALC:    if (last_step) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    div_step #(.VW(VW)) u_step (
        .rem_in  (rem_work),
        .dvd_bit (dvd_sh[DW-1]),
        .divisor (dvs),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    // Dividend bits shift out the top while quotient bits shift in at the bottom.
    always_ff @(posedge clk) begin
        if (accept) begin
            dvd_sh <= Dividend;
            dvs    <= Divisor;
        end else if (state == CALC) begin
            dvd_sh <= {dvd_sh[DW-2:0], q_bit};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            rem_work <= '0;
            Quo      <= '0;
            Rem      <= '0;
            div_zero <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            rem_work <= '0;
            div_zero <= (Divisor == '0);
            if (Divisor == '0) begin
                Quo <= QUO_DZ;
                Rem <= Dividend[VW-1:0];
            end
        end else if (state == CALC) begin
            cnt      <= cnt + 1'b1;
            rem_work <= rem_nxt;
            if (last_step) begin
                Quo <= {dvd_sh[DW-2:0], q_bit};
                Rem <= rem_nxt[VW-1:0];
            end
        end
    end
endmodule
